// File: rtl/aes_stream_pkg.sv
// Shared types and helpers for the AES stream sequencer.
// Holds the FSM encoding, the core config layout and its packing function.
package aes_stream_pkg;

   localparam int unsigned CNT_W        = 32;
   localparam int unsigned CFG_W        = 256;
   localparam int unsigned CFG_ELEM_LSB = 64;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_KEY_ISSUE = 3'd1,
      ST_KEY_WAIT  = 3'd2,
      ST_STREAM    = 3'd3,
      ST_DRAIN     = 3'd4,
      ST_DONE      = 3'd5
   } state_e;

   // Config word seen by the AES core: {128'h0, 32'h0, elems, 64'h0}
   typedef struct packed {
      logic [127:0]     rsvd_hi;
      logic [31:0]      rsvd_mid;
      logic [CNT_W-1:0] elems;
      logic [63:0]      rsvd_lo;
   } aes_cfg_t;

   function automatic aes_cfg_t pack_config(input logic [CNT_W-1:0] elems);
      logic [CFG_W-1:0] cfg;
      cfg = '0;
      cfg[CFG_ELEM_LSB +: CNT_W] = elems;
      return aes_cfg_t'(cfg);
   endfunction

endpackage

// File: rtl/aes_stream_skid.sv
// One-entry output register with valid/ready towards the AES core.
// A new beat may load while the held beat is being consumed.
module aes_stream_skid #(
   parameter int unsigned DATA_W = 512
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_load,
   input  logic [DATA_W-1:0] in_data,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              can_load_c
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (in_load) begin
         valid_d = 1'b1;
         data_d  = in_data;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign can_load_c = ~valid_q | out_ready;
   assign out_valid  = valid_q;
   assign out_data   = data_q;

endmodule

// File: rtl/aes_stream_ctrl.sv
// Sequences one AES job: key expansion, schedule assembly, then admits
// exactly job_elems data beats into the core and counts the results back.
module aes_stream_ctrl
   import aes_stream_pkg::*;
#(
   parameter int unsigned N_PIPES   = 4,
   parameter int unsigned KEY_WIDTH = 256,
   parameter int unsigned HALF_W    = 1024
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     job_valid,
   output logic                     job_ready,
   input  logic [KEY_WIDTH-1:0]     job_key,
   input  logic [31:0]              job_elems,
   output logic                     klsb_ivalid,
   output logic                     kmsb_ivalid,
   input  logic                     klsb_oready,
   input  logic                     kmsb_oready,
   output logic [KEY_WIDTH-1:0]     kexp_key,
   input  logic                     klsb_ovalid,
   input  logic                     kmsb_ovalid,
   output logic                     klsb_iready,
   output logic                     kmsb_iready,
   input  logic [HALF_W-1:0]        klsb_data,
   input  logic [HALF_W-1:0]        kmsb_data,
   output logic [2*HALF_W-1:0]      sched_out,
   output logic                     sched_valid,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [N_PIPES*128-1:0]   s_data,
   output logic                     aes_ivalid,
   input  logic                     aes_oready,
   output logic [N_PIPES*128-1:0]   aes_datain,
   output logic [255:0]             aes_config,
   input  logic                     aes_ovalid,
   input  logic                     m_ready,
   output logic                     aes_iready,
   output logic                     m_valid,
   output logic [N_PIPES*128-1:0]   m_data,
   input  logic [N_PIPES*128-1:0]   aes_dataout,
   output logic                     done
);

   localparam int unsigned DATA_W  = N_PIPES * 128;
   localparam int unsigned SCHED_W = 2 * HALF_W;

   state_e               state_q, state_d;
   logic [KEY_WIDTH-1:0] key_q, key_d;
   logic [CNT_W-1:0]     elems_q, elems_d;
   aes_cfg_t             cfg_q, cfg_d;
   logic                 klsb_ivalid_q, klsb_ivalid_d;
   logic                 kmsb_ivalid_q, kmsb_ivalid_d;
   logic                 klsb_iready_q, klsb_iready_d;
   logic                 kmsb_iready_q, kmsb_iready_d;
   logic                 lsb_got_q, lsb_got_d;
   logic                 msb_got_q, msb_got_d;
   logic [SCHED_W-1:0]   sched_q, sched_d;
   logic                 sched_valid_q, sched_valid_d;
   logic [CNT_W-1:0]     issued_q, issued_d;
   logic [CNT_W-1:0]     retired_q, retired_d;
   logic                 job_ready_q, job_ready_d;
   logic                 done_q, done_d;

   logic                 s_ready_c;
   logic                 load_c;
   logic                 skid_can_load_c;
   logic                 skid_valid;

   always_comb begin
      state_d       = state_q;
      key_d         = key_q;
      elems_d       = elems_q;
      cfg_d         = cfg_q;
      klsb_ivalid_d = klsb_ivalid_q;
      kmsb_ivalid_d = kmsb_ivalid_q;
      lsb_got_d     = lsb_got_q;
      msb_got_d     = msb_got_q;
      sched_d       = sched_q;
      sched_valid_d = sched_valid_q;
      issued_d      = issued_q;
      retired_d     = retired_q;
      s_ready_c     = 1'b0;
      load_c        = 1'b0;

      // Results are only counted while a job is streaming; the guard keeps the count from wrapping
      if ((state_q == ST_STREAM || state_q == ST_DRAIN) && aes_ovalid && m_ready
          && (retired_q < elems_q)) begin
         retired_d = retired_q + CNT_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (job_valid) begin
               key_d         = job_key;
               elems_d       = job_elems;
               cfg_d         = pack_config(job_elems);
               sched_valid_d = 1'b0;
               lsb_got_d     = 1'b0;
               msb_got_d     = 1'b0;
               issued_d      = '0;
               retired_d     = '0;
               klsb_ivalid_d = 1'b1;
               kmsb_ivalid_d = 1'b1;
               state_d       = ST_KEY_ISSUE;
            end
         end
         ST_KEY_ISSUE: begin
            if (klsb_oready) klsb_ivalid_d = 1'b0;
            if (kmsb_oready) kmsb_ivalid_d = 1'b0;
            if (!klsb_ivalid_d && !kmsb_ivalid_d) state_d = ST_KEY_WAIT;
         end
         ST_KEY_WAIT: begin
            // Halves may land in either order or together
            if (klsb_ovalid && klsb_iready_q) begin
               sched_d[HALF_W-1:0] = klsb_data;
               lsb_got_d           = 1'b1;
            end
            if (kmsb_ovalid && kmsb_iready_q) begin
               sched_d[SCHED_W-1:HALF_W] = kmsb_data;
               msb_got_d                 = 1'b1;
            end
            if (lsb_got_q && msb_got_q) begin
               sched_valid_d = 1'b1;
               state_d       = (elems_q == '0) ? ST_DONE : ST_STREAM;
            end
         end
         ST_STREAM: begin
            s_ready_c = (issued_q < elems_q) && skid_can_load_c;
            load_c    = s_valid && s_ready_c;
            if (load_c) issued_d = issued_q + CNT_W'(1);
            if ((issued_q == elems_q) && !skid_valid) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (retired_d == elems_q) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      klsb_iready_d = (state_d == ST_KEY_WAIT) && !lsb_got_d;
      kmsb_iready_d = (state_d == ST_KEY_WAIT) && !msb_got_d;
      job_ready_d   = (state_d == ST_IDLE);
      done_d        = (state_d == ST_DONE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         key_q         <= '0;
         elems_q       <= '0;
         cfg_q         <= '0;
         klsb_ivalid_q <= 1'b0;
         kmsb_ivalid_q <= 1'b0;
         klsb_iready_q <= 1'b0;
         kmsb_iready_q <= 1'b0;
         lsb_got_q     <= 1'b0;
         msb_got_q     <= 1'b0;
         sched_q       <= '0;
         sched_valid_q <= 1'b0;
         issued_q      <= '0;
         retired_q     <= '0;
         job_ready_q   <= 1'b1;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         key_q         <= key_d;
         elems_q       <= elems_d;
         cfg_q         <= cfg_d;
         klsb_ivalid_q <= klsb_ivalid_d;
         kmsb_ivalid_q <= kmsb_ivalid_d;
         klsb_iready_q <= klsb_iready_d;
         kmsb_iready_q <= kmsb_iready_d;
         lsb_got_q     <= lsb_got_d;
         msb_got_q     <= msb_got_d;
         sched_q       <= sched_d;
         sched_valid_q <= sched_valid_d;
         issued_q      <= issued_d;
         retired_q     <= retired_d;
         job_ready_q   <= job_ready_d;
         done_q        <= done_d;
      end
   end

   aes_stream_skid #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clock      (clock),
      .reset      (reset),
      .in_load    (load_c),
      .in_data    (s_data),
      .out_ready  (aes_oready),
      .out_valid  (skid_valid),
      .out_data   (aes_datain),
      .can_load_c (skid_can_load_c)
   );

   assign job_ready   = job_ready_q;
   assign klsb_ivalid = klsb_ivalid_q;
   assign kmsb_ivalid = kmsb_ivalid_q;
   assign klsb_iready = klsb_iready_q;
   assign kmsb_iready = kmsb_iready_q;
   assign kexp_key    = key_q;
   assign sched_out   = sched_q;
   assign sched_valid = sched_valid_q;
   assign s_ready     = s_ready_c;
   assign aes_ivalid  = skid_valid;
   assign aes_config  = cfg_q;
   assign done        = done_q;

   // Result path is a straight pass-through to the downstream sink
   assign aes_iready  = m_ready;
   assign m_valid     = aes_ovalid;
   assign m_data      = aes_dataout;

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Randomized scoreboard bench for aes_stream_ctrl with emulated key units,
// host source, AES core and downstream sink.
module tb_aes_stream_ctrl;

   localparam int unsigned NP      = 4;
   localparam int unsigned KW      = 256;
   localparam int unsigned HW      = 1024;
   localparam int unsigned DW      = NP * 128;
   localparam int unsigned SW      = 2 * HW;
   localparam int          TIMEOUT = 2000;
   localparam logic [DW-1:0] XMASK = {16{32'h5a5a_0f0f}};

   logic            clock = 1'b0;
   logic            reset;
   logic            job_valid, job_ready;
   logic [KW-1:0]   job_key;
   logic [31:0]     job_elems;
   logic            klsb_ivalid, kmsb_ivalid, klsb_oready, kmsb_oready;
   logic [KW-1:0]   kexp_key;
   logic            klsb_ovalid, kmsb_ovalid, klsb_iready, kmsb_iready;
   logic [HW-1:0]   klsb_data, kmsb_data;
   logic [SW-1:0]   sched_out;
   logic            sched_valid;
   logic            s_valid, s_ready;
   logic [DW-1:0]   s_data;
   logic            aes_ivalid, aes_oready;
   logic [DW-1:0]   aes_datain;
   logic [255:0]    aes_config;
   logic            aes_ovalid, m_ready, aes_iready, m_valid;
   logic [DW-1:0]   m_data, aes_dataout;
   logic            done;

   always #5 clock = ~clock;

   aes_stream_ctrl #(.N_PIPES(NP), .KEY_WIDTH(KW), .HALF_W(HW)) dut (
      .clock(clock), .reset(reset),
      .job_valid(job_valid), .job_ready(job_ready), .job_key(job_key), .job_elems(job_elems),
      .klsb_ivalid(klsb_ivalid), .kmsb_ivalid(kmsb_ivalid),
      .klsb_oready(klsb_oready), .kmsb_oready(kmsb_oready), .kexp_key(kexp_key),
      .klsb_ovalid(klsb_ovalid), .kmsb_ovalid(kmsb_ovalid),
      .klsb_iready(klsb_iready), .kmsb_iready(kmsb_iready),
      .klsb_data(klsb_data), .kmsb_data(kmsb_data),
      .sched_out(sched_out), .sched_valid(sched_valid),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .aes_ivalid(aes_ivalid), .aes_oready(aes_oready), .aes_datain(aes_datain),
      .aes_config(aes_config), .aes_ovalid(aes_ovalid), .m_ready(m_ready),
      .aes_iready(aes_iready), .m_valid(m_valid), .m_data(m_data),
      .aes_dataout(aes_dataout), .done(done)
   );

   int total = 0;
   int bad   = 0;

   // Reference model / emulation state
   logic [HW-1:0]  lsb_half, msb_half;
   int             ldly, mdly, lcnt, mcnt;
   bit             lreq, mreq;
   logic [DW-1:0]  host_q[$];
   logic [DW-1:0]  exp_beat[$];
   logic [DW-1:0]  exp_res[$];
   logic [DW-1:0]  core_q[$];
   int             oready_mode = 0;
   logic [3:0]     pat_v = 4'b1001;
   int             pat_i = 0;
   bit             hold_valid = 1'b0;
   bit             kor_rand = 1'b0;
   bit             core_rand = 1'b0;
   bit             sched_armed = 1'b0;
   int unsigned    cur_elems, accepted, retired;
   int             done_cnt, aes_iv_cycles;

   task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
      int k;
      k = 0;
      total++;
      if (act !== exp) begin
         for (int i = 0; i < int'(SW / 64); i++) begin
            if (act[i*64 +: 64] !== exp[i*64 +: 64]) begin
               k = i;
               break;
            end
         end
         bad++;
         $display("FAIL %s: got %h want %h (64b word %0d) t=%0t", name,
                  act[k*64 +: 64], exp[k*64 +: 64], k, $time);
      end
   endtask

   function automatic logic [HW-1:0] rand_half();
      logic [HW-1:0] r;
      for (int i = 0; i < int'(HW / 32); i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [DW-1:0] rand_beat();
      logic [DW-1:0] r;
      for (int i = 0; i < int'(DW / 32); i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [KW-1:0] rand_key();
      logic [KW-1:0] r;
      for (int i = 0; i < int'(KW / 32); i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Stand-in for the AES transform applied by the emulated core
   function automatic logic [DW-1:0] xform(input logic [DW-1:0] d);
      return d ^ XMASK;
   endfunction

   // Drive emulated peripherals just after each active edge
   always begin
      @(posedge clock);
      #1;
      if (reset) begin
         klsb_oready = 1'b0; kmsb_oready = 1'b0;
         klsb_ovalid = 1'b0; kmsb_ovalid = 1'b0;
         s_valid = 1'b0; aes_oready = 1'b0; aes_ovalid = 1'b0; m_ready = 1'b0;
         s_data = '0; aes_dataout = '0;
      end else begin
         klsb_oready = kor_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         kmsb_oready = kor_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         if (lreq && lcnt > 0) lcnt--;
         if (mreq && mcnt > 0) mcnt--;
         klsb_ovalid = lreq && (lcnt == 0);
         kmsb_ovalid = mreq && (mcnt == 0);
         klsb_data   = lsb_half;
         kmsb_data   = msb_half;
         s_valid = (host_q.size() > 0) && (hold_valid || ($urandom_range(0, 3) != 0));
         s_data  = (host_q.size() > 0) ? host_q[0] : '0;
         case (oready_mode)
            0: aes_oready = 1'b1;
            1: aes_oready = 1'($urandom_range(0, 1));
            default: begin
               aes_oready = pat_v[pat_i];
               pat_i = (pat_i + 1) % 4;
            end
         endcase
         aes_ovalid  = (core_q.size() > 0) && (!core_rand || ($urandom_range(0, 2) != 0));
         aes_dataout = (core_q.size() > 0) ? core_q[0] : '0;
         m_ready     = core_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: record handshakes that complete at the next edge and score them
   always begin
      @(negedge clock);
      if (!reset) begin
         if (klsb_ivalid && klsb_oready) begin lreq = 1'b1; lcnt = ldly; end
         if (kmsb_ivalid && kmsb_oready) begin mreq = 1'b1; mcnt = mdly; end
         if (klsb_ovalid && klsb_iready) lreq = 1'b0;
         if (kmsb_ovalid && kmsb_iready) mreq = 1'b0;
         if (s_ready) check("s_ready_limit", SW'(accepted < cur_elems), SW'(1));
         if (s_valid && s_ready) begin
            void'(host_q.pop_front());
            accepted++;
         end
         if (aes_ivalid) aes_iv_cycles++;
         if (aes_ivalid && aes_oready) begin
            check("beat_expected", SW'(exp_beat.size() > 0), SW'(1));
            if (exp_beat.size() > 0) check("beat_data", SW'(aes_datain), SW'(exp_beat.pop_front()));
            core_q.push_back(xform(aes_datain));
         end
         if (m_valid && m_ready) begin
            check("result_expected", SW'(exp_res.size() > 0), SW'(1));
            if (exp_res.size() > 0) check("result_data", SW'(m_data), SW'(exp_res.pop_front()));
            if (core_q.size() > 0) void'(core_q.pop_front());
            retired++;
         end
         if (done) done_cnt++;
         if (sched_armed && sched_valid) begin
            logic [255:0] cfg_exp;
            cfg_exp = '0;
            cfg_exp[95:64] = cur_elems;
            sched_armed = 1'b0;
            check("sched", sched_out, {msb_half, lsb_half});
            check("config", SW'(aes_config), SW'(cfg_exp));
         end
      end
   end

   task automatic check_reset_outputs();
      check("rst_ctrl", SW'({klsb_ivalid, kmsb_ivalid, klsb_iready, kmsb_iready,
                            sched_valid, aes_ivalid, s_ready, done}), '0);
      check("rst_job_ready", SW'(job_ready), SW'(1));
      check("rst_sched", sched_out, '0);
      check("rst_datain", SW'(aes_datain), '0);
      check("rst_kexp_key", SW'(kexp_key), '0);
      check("rst_config", SW'(aes_config), '0);
   endtask

   task automatic start_job(input logic [KW-1:0] key, input int unsigned elems,
                            input int ld, input int md, input int extra, input bit pat_data);
      logic [DW-1:0]  beat;
      logic [127:0]   lane;
      bit             got;
      lane = 128'h00000001000000010000000100000001;
      host_q.delete(); exp_beat.delete(); exp_res.delete();
      ldly = ld; mdly = md;
      lsb_half = rand_half(); msb_half = rand_half();
      cur_elems = elems; accepted = 0; retired = 0; done_cnt = 0; aes_iv_cycles = 0; pat_i = 0;
      for (int i = 0; i < int'(elems) + extra; i++) begin
         beat = pat_data ? {NP{lane}} : rand_beat();
         host_q.push_back(beat);
         if (i < int'(elems)) begin
            exp_beat.push_back(beat);
            exp_res.push_back(xform(beat));
         end
      end
      @(posedge clock); #1;
      job_key = key; job_elems = elems; job_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < TIMEOUT; i++) begin
         @(negedge clock);
         if (job_ready) begin got = 1'b1; break; end
      end
      check("job_accept", SW'(got), SW'(1));
      @(posedge clock); #1;
      job_valid = 1'b0;
      sched_armed = 1'b1;
      @(negedge clock);
      check("key_request", SW'({klsb_ivalid, kmsb_ivalid}), SW'(2'b11));
      check("kexp_key", SW'(kexp_key), SW'(key));
   endtask

   task automatic finish_job(input int extra);
      bit got;
      got = 1'b0;
      for (int i = 0; i < TIMEOUT; i++) begin
         @(negedge clock);
         if (done) begin got = 1'b1; break; end
      end
      check("done_seen", SW'(got), SW'(1));
      if (got) begin
         check("done_sched_valid", SW'(sched_valid), SW'(1));
         check("done_sched_hold", sched_out, {msb_half, lsb_half});
         @(negedge clock);
         check("done_pulse", SW'({done, job_ready, sched_valid}), SW'(3'b011));
         check("issued", SW'(accepted), SW'(cur_elems));
         check("retired", SW'(retired), SW'(cur_elems));
         check("queues_empty", SW'(exp_beat.size() + exp_res.size()), '0);
         check("host_left", SW'(host_q.size()), SW'(extra));
         check("done_count", SW'(done_cnt), SW'(1));
         check("cfg_elems", SW'(aes_config[95:64]), SW'(cur_elems));
      end
   endtask

   task automatic pulse_reset();
      @(posedge clock); #3;
      reset = 1'b1;
      #1;
      check_reset_outputs();
      host_q.delete(); exp_beat.delete(); exp_res.delete(); core_q.delete();
      lreq = 1'b0; mreq = 1'b0; sched_armed = 1'b0; job_valid = 1'b0;
      done_cnt = 0; cur_elems = 0; accepted = 0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("no_done_after_abort", SW'(done_cnt), '0);
      check_reset_outputs();
   endtask

   initial begin
      bit got;
      reset = 1'b1;
      job_valid = 1'b0; job_key = '0; job_elems = '0;
      klsb_oready = 1'b0; kmsb_oready = 1'b0; klsb_ovalid = 1'b0; kmsb_ovalid = 1'b0;
      klsb_data = '0; kmsb_data = '0;
      s_valid = 1'b0; s_data = '0; aes_oready = 1'b0; aes_ovalid = 1'b0;
      aes_dataout = '0; m_ready = 1'b0;
      lreq = 1'b0; mreq = 1'b0; lcnt = 0; mcnt = 0; ldly = 0; mdly = 0;
      cur_elems = 0; accepted = 0; retired = 0; done_cnt = 0; aes_iv_cycles = 0;
      lsb_half = '0; msb_half = '0;
      repeat (3) @(negedge clock);
      check_reset_outputs();
      @(posedge clock); #1;
      reset = 1'b0;

      // Directed key, LSB half first, all-ones-lane data
      start_job({32'h00000001, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 128'h0}, 4, 0, 2, 0, 1'b1);
      finish_job(0);
      // MSB half well ahead of LSB, then both halves together
      start_job(rand_key(), 6, 5, 0, 0, 1'b0);
      finish_job(0);
      start_job(rand_key(), 3, 2, 2, 0, 1'b0);
      finish_job(0);
      // Core ready toggling 1,0,0,1
      oready_mode = 2;
      start_job(rand_key(), 4, 0, 0, 0, 1'b1);
      finish_job(0);
      oready_mode = 0;
      // Empty job
      start_job(rand_key(), 0, 1, 3, 0, 1'b0);
      finish_job(0);
      check("zero_elem_ivalid", SW'(aes_iv_cycles), '0);

      // Abort in KEY_WAIT
      start_job(rand_key(), 5, 40, 0, 0, 1'b0);
      got = 1'b0;
      for (int i = 0; i < TIMEOUT; i++) begin
         @(negedge clock);
         if (klsb_iready) begin got = 1'b1; break; end
      end
      check("reach_key_wait", SW'(got), SW'(1));
      pulse_reset();
      start_job(rand_key(), 5, 1, 1, 0, 1'b0);
      finish_job(0);

      // Abort in STREAM
      start_job(rand_key(), 20, 0, 0, 0, 1'b0);
      got = 1'b0;
      for (int i = 0; i < TIMEOUT; i++) begin
         @(negedge clock);
         if (aes_ivalid) begin got = 1'b1; break; end
      end
      check("reach_stream", SW'(got), SW'(1));
      pulse_reset();
      start_job(rand_key(), 4, 0, 0, 0, 1'b0);
      finish_job(0);

      // Host keeps offering a fifth beat
      hold_valid = 1'b1;
      start_job(rand_key(), 4, 0, 0, 1, 1'b0);
      finish_job(1);
      hold_valid = 1'b0;

      // Fully randomized handshakes
      kor_rand = 1'b1; core_rand = 1'b1; oready_mode = 1;
      for (int j = 0; j < 6; j++) begin
         start_job(rand_key(), $urandom_range(1, 12), int'($urandom_range(0, 6)),
                   int'($urandom_range(0, 6)), 0, 1'b0);
         finish_job(0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
